// File: rtl/dkong_audio_mixer_if.sv
// Channel bus into the soundboard mixer and the mixed sample stream out of it.
// The master drives channel data/gain/mute; the slave (mixer) returns the sample and strobe.
interface dkong_audio_mixer_if #(
  parameter int CHANNELS = 4,
  parameter int IN_W     = 16,
  parameter int GAIN_W   = 8,
  parameter int OUT_W    = 16
);
  logic        [CHANNELS*IN_W-1:0]   I_CH_DAT;
  logic        [CHANNELS*GAIN_W-1:0] I_CH_GAIN;
  logic        [CHANNELS-1:0]        I_CH_MUTE;
  logic signed [OUT_W-1:0]           O_SOUND_DAT;
  logic                              O_SAMPLE_EN;
  logic                              O_CLIP;

  modport master (
    output I_CH_DAT, I_CH_GAIN, I_CH_MUTE,
    input  O_SOUND_DAT, O_SAMPLE_EN, O_CLIP
  );

  modport slave (
    input  I_CH_DAT, I_CH_GAIN, I_CH_MUTE,
    output O_SOUND_DAT, O_SAMPLE_EN, O_CLIP
  );
endinterface

// File: rtl/dkong_audio_mixer.sv
// Time-multiplexed gain/mute/saturating mixer: one multiply per cycle, one output sample per DIV cycles.
// Latency: capture edge E, sample and one-cycle strobe at E+CHANNELS+1; no backpressure, output is held.
module dkong_audio_mixer #(
  parameter int CHANNELS    = 4,
  parameter int IN_W        = 16,
  parameter int GAIN_W      = 8,
  parameter int OUT_W       = 16,
  parameter int CLOCK_RATE  = 24000000,
  parameter int SAMPLE_RATE = 48000
) (
  input  logic I_CLK,
  input  logic I_RST,
  dkong_audio_mixer_if.slave bus
);
  localparam int DIV    = CLOCK_RATE / SAMPLE_RATE;
  localparam int CNT_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PROD_W = IN_W + GAIN_W + 1;
  localparam int ACC_W  = IN_W + GAIN_W + $clog2(CHANNELS) + 1;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  if (DIV < CHANNELS + 3) begin : g_bad_div
    $error("dkong_audio_mixer: CLOCK_RATE/SAMPLE_RATE must be at least CHANNELS+3");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_SAT} state_t;

  state_t                   state_q;
  logic [CNT_W-1:0]         cnt_q;
  logic [IDX_W-1:0]         idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [IN_W-1:0]   snap_dat_q  [CHANNELS];
  logic [GAIN_W-1:0]        snap_gain_q [CHANNELS];
  logic                     snap_mute_q [CHANNELS];
  logic signed [OUT_W-1:0]  sound_q;
  logic                     sample_en_q;
  logic                     clip_q;

  logic                     tick;
  logic signed [PROD_W-1:0] prod_d;
  logic signed [ACC_W-1:0]  acc_d;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [OUT_W-1:0]  sound_d;
  logic                     clip_d;

  assign tick = (cnt_q == CNT_W'(DIV - 1));

  // Gain is unsigned; a zero MSB keeps it positive in the signed multiply.
  always_comb begin
    prod_d = '0;
    if (!snap_mute_q[idx_q]) begin
      prod_d = PROD_W'(snap_dat_q[idx_q]) * PROD_W'($signed({1'b0, snap_gain_q[idx_q]}));
    end
    acc_d = acc_q + ACC_W'(prod_d);
  end

  always_comb begin
    scaled  = acc_q >>> (GAIN_W - 1);
    sound_d = OUT_W'(scaled);
    clip_d  = 1'b0;
    if (scaled > MAX_V) begin
      sound_d = OUT_W'(MAX_V);
      clip_d  = 1'b1;
    end else if (scaled < MIN_V) begin
      sound_d = OUT_W'(MIN_V);
      clip_d  = 1'b1;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      sound_q     <= '0;
      sample_en_q <= 1'b0;
      clip_q      <= 1'b0;
      for (int k = 0; k < CHANNELS; k++) begin
        snap_dat_q[k]  <= '0;
        snap_gain_q[k] <= '0;
        snap_mute_q[k] <= 1'b0;
      end
    end else begin
      cnt_q       <= tick ? '0 : cnt_q + CNT_W'(1);
      sample_en_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            for (int k = 0; k < CHANNELS; k++) begin
              snap_dat_q[k]  <= bus.I_CH_DAT[k*IN_W +: IN_W];
              snap_gain_q[k] <= bus.I_CH_GAIN[k*GAIN_W +: GAIN_W];
              snap_mute_q[k] <= bus.I_CH_MUTE[k];
            end
            acc_q   <= '0;
            idx_q   <= '0;
            state_q <= S_ACC;
          end
        end
        S_ACC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(CHANNELS - 1)) begin
            state_q <= S_SAT;
          end
        end
        S_SAT: begin
          sound_q     <= sound_d;
          clip_q      <= clip_d;
          sample_en_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.O_SOUND_DAT = sound_q;
  assign bus.O_SAMPLE_EN = sample_en_q;
  assign bus.O_CLIP      = clip_q;
endmodule

// File: doc/dkong_audio_mixer.md
# dkong_audio_mixer

Parametrised, time-multiplexed audio mixer and sample-rate generator that replaces the fixed shift-and-add mix at the soundboard output. It takes N signed channel streams (digital DAC/filter path, WAV playback, walk sound, future samples), applies a per-channel unsigned gain and mute, sums with saturation, and emits one signed sample per output period with a strobe. All channel inputs and gains are snapshotted on a single edge per sample, so every output sample is coherent with the sample strobe.

## Interface
- CHANNELS, 4: number of input channels, 1..16.
- IN_W, 16: signed width of each channel sample.
- GAIN_W, 8: unsigned gain width; unity = 2^(GAIN_W-1).
- OUT_W, 16: signed output width, OUT_W <= IN_W+1.
- CLOCK_RATE, 24000000: I_CLK frequency in Hz.
- SAMPLE_RATE, 48000: output sample rate in Hz; DIV = CLOCK_RATE/SAMPLE_RATE (integer division); elaboration error if DIV < CHANNELS+3.

- I_CLK  in  1  system clock (24 MHz domain).
- I_RST  in  1  asynchronous, active-high reset.
- I_CH_DAT  in  CHANNELS*IN_W  packed signed samples; channel k at [k*IN_W +: IN_W].
- I_CH_GAIN  in  CHANNELS*GAIN_W  packed unsigned gains; channel k at [k*GAIN_W +: GAIN_W].
- I_CH_MUTE  in  CHANNELS  1 = channel k contributes 0 regardless of gain.
- O_SOUND_DAT  out  OUT_W  signed mixed sample, held between updates.
- O_SAMPLE_EN  out  1  one-cycle pulse in the cycle O_SOUND_DAT takes a new value.
- O_CLIP  out  1  1 if the current O_SOUND_DAT was saturated; updated with O_SOUND_DAT.

## Operation
- Divider: counter 0..DIV-1, increments every cycle, wraps to 0. Tick = counter == DIV-1.
- On the tick edge: capture I_CH_DAT, I_CH_GAIN, I_CH_MUTE into snapshot registers; clear accumulator; FSM IDLE -> ACC, channel index 0.
- ACC (CHANNELS cycles): each cycle, acc += muted ? 0 : snap_dat[idx] * {1'b0, snap_gain[idx]} (signed); idx increments; after idx = CHANNELS-1 -> SAT.
- Accumulator width ACC_W = IN_W + GAIN_W + clog2(CHANNELS) + 1; no internal overflow possible.
- SAT (1 cycle): scaled = acc >>> (GAIN_W-1) (arithmetic, floor toward -inf); clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; register O_SOUND_DAT, set O_CLIP = clamp active, assert O_SAMPLE_EN; -> IDLE.
- Inputs are ignored outside the tick edge; changes during ACC/SAT do not affect the sample in flight.
- Because DIV >= CHANNELS+3, a tick never arrives outside IDLE; no overlap handling needed.
- Gain 0 with no mute contributes 0; mute has priority over any gain.

## Timing
- Reset values: counter 0, FSM IDLE, accumulator 0, snapshots 0, O_SOUND_DAT 0, O_SAMPLE_EN 0, O_CLIP 0.
- First tick at the DIV-th rising edge after I_RST deasserts; subsequent ticks every DIV cycles.
- Latency: capture edge E; ACC edges E+1..E+CHANNELS; O_SOUND_DAT/O_CLIP/O_SAMPLE_EN change at edge E+CHANNELS+1; O_SAMPLE_EN deasserts at E+CHANNELS+2.
- O_SAMPLE_EN period exactly DIV cycles, width exactly 1 cycle.
- Reset asserted mid-ACC or mid-SAT: partial sum discarded, all outputs return to reset values immediately (async); no strobe emitted for the aborted sample.

## Test plan
- CHANNELS=4, IN_W=16, GAIN_W=8, OUT_W=16, CLOCK_RATE=1000, SAMPLE_RATE=100 (DIV=10): ch0=1000 gain 128, ch1..3 muted -> O_SOUND_DAT=1000, O_CLIP=0, O_SAMPLE_EN one cycle every 10 cycles, first pulse 5 edges after the first tick edge.
- Scaling/rounding: ch0=-1000 gain 64, ch1=3 gain 64, ch2=-3 gain 64, ch3 gain 0 -> (-64000+192-192)>>>7 = -500; ch0 alone=-3 gain 64 -> -2 (floor).
- Saturation: all four channels 30000 gain 255 -> 32767, O_CLIP=1; all -32768 gain 255 -> -32768, O_CLIP=1; next sample ch0=1 gain 128 only -> 1, O_CLIP=0.
- Coherence: ch0=100 gain 128 at tick, change ch0 to 5000 one cycle after tick -> that sample is 100; next sample 5000.
- Mute priority: ch0=2000 gain 255 with I_CH_MUTE[0]=1, others muted -> 0, O_CLIP=0.
- Reset mid-operation: assert I_RST 2 cycles after a tick -> O_SOUND_DAT=0, O_SAMPLE_EN=0 for the aborted sample; after release, next strobe at edge 10+5 after deassertion.
